// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath select encodings and the bundled control-word struct.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU   = 2'b00;
  localparam logic [1:0] PCSRC_OUT   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: state register plus one combinational case that
// produces next state and every datapath control, stalling on mem_ready.
module mc_control
  import mips_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit WAIT_EN         = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t cur_state, nxt_state;
  ctrl_t  c;
  logic   rdy;

  assign rdy = WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    c         = '0;
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        nxt_state   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_ADDI:      nxt_state = S_ADDIEX;
          OP_J:         nxt_state = S_JUMP;
          default:      nxt_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        // IR is frozen, so the decode-time opcode still selects load vs store
        nxt_state   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
        nxt_state  = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = rdy;
        nxt_state    = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
        nxt_state   = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_op     = ALUOP_SUB;
        c.pc_src     = PCSRC_OUT;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        nxt_state   = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = PCSRC_JUMP;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        c.illegal = 1'b1;
        nxt_state = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      end
      default: nxt_state = S_FETCH;
    endcase
    // reset kills any in-flight access (including a stalled store) immediately
    if (rst) c = '0;
  end

  assign pc_write   = c.pc_write;
  assign branch     = c.branch;
  assign iord       = c.iord;
  assign mem_read   = c.mem_read;
  assign mem_write  = c.mem_write;
  assign ir_write   = c.ir_write;
  assign mem_to_reg = c.mem_to_reg;
  assign reg_dst    = c.reg_dst;
  assign reg_write  = c.reg_write;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign alu_op     = c.alu_op;
  assign pc_src     = c.pc_src;
  assign instr_done = c.instr_done;
  assign illegal    = c.illegal;
  assign state      = cur_state;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: instruction traces, memory stalls, illegal
// opcode handling for both halt settings, and reset during a stalled store.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write, branch, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  logic       n_pc_write, n_branch, n_iord, n_mem_read, n_mem_write, n_ir_write, n_mem_to_reg;
  logic       n_reg_dst, n_reg_write, n_alu_src_a, n_instr_done, n_illegal;
  logic [1:0] n_alu_src_b, n_alu_op, n_pc_src;
  logic [3:0] n_state;

  int tests = 0;
  int failed = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  mc_control #(.HALT_ON_ILLEGAL(1'b1), .WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  mc_control #(.HALT_ON_ILLEGAL(1'b0), .WAIT_EN(1'b1)) dut_nh (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .branch(n_branch), .iord(n_iord), .mem_read(n_mem_read),
    .mem_write(n_mem_write), .ir_write(n_ir_write), .mem_to_reg(n_mem_to_reg),
    .reg_dst(n_reg_dst), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .pc_src(n_pc_src),
    .instr_done(n_instr_done), .illegal(n_illegal), .state(n_state)
  );

  logic [17:0] outs;
  assign outs = {pc_write, branch, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                 instr_done, illegal};

  always @(posedge clk) if (instr_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    tick; tick;
    chk("rst_state", state, 0);
    chk("rst_outs_zero", outs, 0);

    rst = 1'b0; #1;
    chk("fetch_state", state, 0);
    chk("fetch_mem_read", mem_read, 1);
    chk("fetch_ir_write", ir_write, 1);
    chk("fetch_pc_write", pc_write, 1);
    chk("fetch_srcb", alu_src_b, 2'b01);

    // lw: 0,1,2,3,4
    opcode = 6'b100011;
    done_cnt = 0;
    tick; chk("lw_s1", state, 1); chk("lw_dec_srcb", alu_src_b, 2'b11);
    tick; chk("lw_s2", state, 2); chk("lw_adr_srca", alu_src_a, 1); chk("lw_adr_srcb", alu_src_b, 2'b10);
    tick; chk("lw_s3", state, 3); chk("lw_rd_iord", iord, 1); chk("lw_rd_mem_read", mem_read, 1);
    tick; chk("lw_s4", state, 4); chk("lw_wb_reg_write", reg_write, 1);
          chk("lw_wb_m2r", mem_to_reg, 1); chk("lw_wb_done", instr_done, 1);
    tick; chk("lw_back_fetch", state, 0); chk("lw_done_once", done_cnt, 1);

    // fetch stall
    mem_ready = 1'b0; #1;
    chk("stall_ir_write", ir_write, 0);
    chk("stall_pc_write", pc_write, 0);
    tick; chk("stall_stay", state, 0);

    // sw with 3 wait cycles in S_MEMWR
    mem_ready = 1'b1; opcode = 6'b101011; done_cnt = 0; wr_cnt = 0;
    tick; tick; chk("sw_s2", state, 2);
    tick; chk("sw_s5", state, 5);
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", state, 5);
      chk("sw_wait_done", instr_done, 0);
      chk("sw_wait_no_read", mem_read, 0);
      if (mem_write === 1'b1) wr_cnt++;
      tick;
    end
    mem_ready = 1'b1; #1;
    chk("sw_rdy_iord", iord, 1);
    chk("sw_rdy_done", instr_done, 1);
    if (mem_write === 1'b1) wr_cnt++;
    chk("sw_write_cycles", wr_cnt, 4);
    tick; chk("sw_back_fetch", state, 0); chk("sw_done_once", done_cnt, 1);

    // R-type: 0,1,6,7
    opcode = 6'b000000;
    tick; chk("r_s1", state, 1);
    tick; chk("r_s6", state, 6); chk("r_alu_op", alu_op, 2'b10); chk("r_srca", alu_src_a, 1);
    tick; chk("r_s7", state, 7); chk("r_reg_dst", reg_dst, 1); chk("r_done", instr_done, 1);
    tick; chk("r_fetch", state, 0);

    // addi: 0,1,9,10
    opcode = 6'b001000;
    tick; tick; chk("addi_s9", state, 9); chk("addi_srcb", alu_src_b, 2'b10);
    tick; chk("addi_s10", state, 10); chk("addi_regw", reg_write, 1); chk("addi_regdst", reg_dst, 0);
    tick; chk("addi_fetch", state, 0);

    // beq: 0,1,8
    opcode = 6'b000100;
    tick; tick; chk("beq_s8", state, 8); chk("beq_branch", branch, 1);
    chk("beq_pc_src", pc_src, 2'b01); chk("beq_alu_op", alu_op, 2'b01);
    chk("beq_no_pcw", pc_write, 0);
    tick; chk("beq_fetch", state, 0);

    // j: 0,1,11
    opcode = 6'b000010;
    tick; tick; chk("j_s11", state, 11); chk("j_pc_src", pc_src, 2'b10); chk("j_pc_write", pc_write, 1);
    tick; chk("j_fetch", state, 0);

    // illegal opcode
    opcode = 6'b111111;
    tick; tick;
    chk("ill_state", state, 15); chk("ill_flag", illegal, 1);
    chk("ill_outs_only_flag", outs, 18'h1);
    chk("ill_nh_state", n_state, 15);
    tick; chk("ill_nh_back", n_state, 0);
    for (int i = 0; i < 10; i++) begin
      chk("ill_hold_state", state, 15);
      chk("ill_hold_flag", illegal, 1);
      tick;
    end

    rst = 1'b1; opcode = 6'b000000; tick; rst = 1'b0; #1;
    chk("rerst_state", state, 0);

    // reset in S_MEMWR with mem_ready low
    opcode = 6'b101011; done_cnt = 0;
    tick; tick; tick; chk("rs_s5", state, 5);
    mem_ready = 1'b0; #1;
    chk("rs_write_pre", mem_write, 1);
    rst = 1'b1; #1;
    chk("rs_write_killed", mem_write, 0);
    chk("rs_outs_zero", outs, 0);
    tick; chk("rs_state", state, 0);
    rst = 1'b0; #1;
    chk("rs_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
